// File: rtl/reg_wr_arb.sv
// Two-requester round-robin write arbiter driving a one-hot register-bank store strobe.
// Optional feature REG_WR_ARB_LOCK_EN adds a lock input that lets a winner keep priority.
module reg_wr_arb #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [WIDTH-1:0]     wdata0,
  input  logic [WIDTH-1:0]     wdata1,
`ifdef REG_WR_ARB_LOCK_EN
  input  logic [1:0]           lock,
`endif
  output logic [1:0]           ack,
  output logic [(2**AW)-1:0]   st,
  output logic [WIDTH-1:0]     d,
  output logic                 busy
);

  localparam int NREG = 2**AW;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic [NREG-1:0]   st_q, st_d;
  logic [1:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  d_q, d_d;
`ifdef REG_WR_ARB_LOCK_EN
  logic              hold_q, hold_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    st_d    = '0;
    ack_d   = '0;
    busy_d  = 1'b0;
    d_d     = d_q;
`ifdef REG_WR_ARB_LOCK_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          // The pointer only breaks ties; a lone requester wins outright.
          win_d = (req == 2'b11) ? ptr_q : req[1];
          if (win_d) begin
            st_d[addr1] = 1'b1;
            d_d         = wdata1;
          end else begin
            st_d[addr0] = 1'b1;
            d_d         = wdata0;
          end
          ack_d[win_d] = 1'b1;
          busy_d       = 1'b1;
          state_d      = WRITE;
`ifdef REG_WR_ARB_LOCK_EN
          hold_d       = lock[win_d];
`endif
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef REG_WR_ARB_LOCK_EN
        ptr_d   = hold_q ? win_q : ~win_q;
`else
        ptr_d   = ~win_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      st_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      d_q     <= '0;
`ifdef REG_WR_ARB_LOCK_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      st_q    <= st_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      d_q     <= d_d;
`ifdef REG_WR_ARB_LOCK_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign st   = st_q;
  assign ack  = ack_q;
  assign busy = busy_q;
  assign d    = d_q;

endmodule

// File: tb/tb_reg_wr_arb.sv
// Directed self-checking bench for reg_wr_arb (default WIDTH=16, AW=2).
module tb_reg_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
`ifdef REG_WR_ARB_LOCK_EN
  logic [1:0]  lock;
`endif
  logic [1:0]  ack;
  logic [3:0]  st;
  logic [15:0] d;
  logic        busy;

  int checks = 0;
  int errors = 0;

  reg_wr_arb #(.WIDTH(16), .AW(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef REG_WR_ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .st(st), .d(d), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00;
    addr0 = 2'd0; addr1 = 2'd0; wdata0 = 16'h0; wdata1 = 16'h0;
`ifdef REG_WR_ARB_LOCK_EN
    lock = 2'b00;
`endif
    #2;
    checks++;
    if ({st, ack, busy, d} !== 23'd0) begin
      errors++;
      $display("FAIL reset_async: st=%b ack=%b busy=%b d=%h, expected all zero", st, ack, busy, d);
    end
    req = 2'b11;
    step();
    step();
    checks++;
    if ({st, ack, busy, d} !== 23'd0) begin
      errors++;
      $display("FAIL reset_held: st=%b ack=%b busy=%b d=%h, expected all zero", st, ack, busy, d);
    end
    req = 2'b00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req = 2'b01; addr0 = 2'd2; wdata0 = 16'hBEEF; addr1 = 2'd3; wdata1 = 16'h1111;
    step();
    checks++;
    if (st !== 4'b0100) begin errors++; $display("FAIL single_st: got %b expected 0100", st); end
    checks++;
    if (d !== 16'hBEEF) begin errors++; $display("FAIL single_d: got %h expected beef", d); end
    checks++;
    if (ack !== 2'b01) begin errors++; $display("FAIL single_ack: got %b expected 01", ack); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    req = 2'b00;
    step();
    checks++;
    if ({st, ack, busy} !== 7'd0 || d !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_after: st=%b ack=%b busy=%b d=%h, expected 0 0 0 beef", st, ack, busy, d);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_ack;
    logic [3:0]  exp_st;
    logic [15:0] exp_d;
    apply_reset();
    addr0 = 2'd0; wdata0 = 16'hA000; addr1 = 2'd3; wdata1 = 16'hB111;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_st  = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      exp_d   = (i % 2 == 0) ? 16'hA000 : 16'hB111;
      step();
      checks++;
      if (ack !== exp_ack || st !== exp_st || d !== exp_d || busy !== 1'b1) begin
        errors++;
        $display("FAIL contention_write%0d: ack=%b st=%b d=%h busy=%b, expected %b %b %h 1",
                 i, ack, st, d, busy, exp_ack, exp_st, exp_d);
      end
      step();
      checks++;
      if ({st, ack, busy} !== 7'd0) begin
        errors++;
        $display("FAIL contention_idle%0d: st=%b ack=%b busy=%b, expected zeros", i, st, ack, busy);
      end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_back_to_back();
    // One requester holding req high gets a write every other cycle.
    apply_reset();
    req = 2'b10; addr1 = 2'd1; wdata1 = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ack !== ((i % 2 == 0) ? 2'b10 : 2'b00) || st !== ((i % 2 == 0) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: ack=%b st=%b, expected %b %b", i, ack, st,
                 (i % 2 == 0) ? 2'b10 : 2'b00, (i % 2 == 0) ? 4'b0010 : 4'b0000);
      end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    req = 2'b01; addr0 = 2'd1; wdata0 = 16'h1234;
    step();
    req = 2'b00;
    step();
    req = 2'b10; addr1 = 2'd1; wdata1 = 16'h5678;
    step();
    checks++;
    if (st !== 4'b0010 || ack !== 2'b10) begin
      errors++;
      $display("FAIL midrst_pre: st=%b ack=%b, expected 0010 10", st, ack);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({st, ack, busy, d} !== 23'd0) begin
      errors++;
      $display("FAIL midrst_abort: st=%b ack=%b busy=%b d=%h, expected all zero", st, ack, busy, d);
    end
    req = 2'b11; addr0 = 2'd2; wdata0 = 16'h9ABC;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (ack !== 2'b01 || st !== 4'b0100 || d !== 16'h9ABC) begin
      errors++;
      $display("FAIL midrst_ptr: ack=%b st=%b d=%h, expected 01 0100 9abc", ack, st, d);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_idle();
    req = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({st, ack, busy} !== 7'd0 || d !== 16'h9ABC) begin
        errors++;
        $display("FAIL idle_cycle%0d: st=%b ack=%b busy=%b d=%h, expected 0 0 0 9abc", i, st, ack, busy, d);
      end
    end
  endtask

`ifdef REG_WR_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    addr0 = 2'd3; wdata0 = 16'hC0C0; addr1 = 2'd0; wdata1 = 16'hD0D0;
    lock = 2'b01; req = 2'b11;
    step();
    checks++;
    if (ack !== 2'b01) begin errors++; $display("FAIL lock_first: ack=%b expected 01", ack); end
    lock = 2'b00;
    step();
    step();
    checks++;
    if (ack !== 2'b01 || st !== 4'b1000) begin
      errors++;
      $display("FAIL lock_second: ack=%b st=%b expected 01 1000", ack, st);
    end
    step();
    step();
    checks++;
    if (ack !== 2'b10 || st !== 4'b0001 || d !== 16'hD0D0) begin
      errors++;
      $display("FAIL lock_release: ack=%b st=%b d=%h expected 10 0001 d0d0", ack, st, d);
    end
    req = 2'b00;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_mid_write();
    test_idle();
`ifdef REG_WR_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of each register in the bank.
REQ-002 The block SHALL have parameter AW, default 2, giving the register address width; the bank holds NREG = 2**AW registers.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have the following requester and bank ports:
- req  input  2  write request per requester; held high until that requester's ack.
- addr0  input  AW  requester 0 target register; stable while req[0] is high.
- addr1  input  AW  requester 1 target register; stable while req[1] is high.
- wdata0  input  WIDTH  requester 0 write data; stable while req[0] is high.
- wdata1  input  WIDTH  requester 1 write data; stable while req[1] is high.
- ack  output  2  one-cycle pulse marking the write of that requester as committed.
- st  output  NREG  one-hot store strobe per bank register; feeds each register's st input.
- d  output  WIDTH  write data bus shared by all bank registers.
- busy  output  1  high while in state WRITE.

Function
REQ-005 The block SHALL implement a two-state FSM: IDLE, WRITE.
REQ-006 In IDLE with any req bit high, the block SHALL latch the winner index, its address and its data at the clock edge, and enter WRITE.
REQ-007 In IDLE with req == 2'b00, the block SHALL remain in IDLE.
REQ-008 In WRITE, the block SHALL drive the following, all from registers with no combinational path from req:
- st one-hot at the latched address.
- d equal to the latched data.
- ack[winner] high.
- busy high.
REQ-009 WRITE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-010 Outside WRITE, st, ack and busy SHALL be all zero; d SHALL hold its last value.
REQ-011 Latency SHALL be one cycle: a req sampled at edge k gives st/ack high from edge k to edge k+1.
REQ-012 Throughput SHALL be one write per two cycles at most.
REQ-013 Arbitration SHALL be round-robin via a 1-bit priority pointer, applied only when both req bits are high in IDLE:
- pointer 0 → requester 0 wins.
- pointer 1 → requester 1 wins.
REQ-014 When only one req bit is high, that requester SHALL win regardless of the pointer.
REQ-015 On leaving WRITE, the pointer SHALL be set to the requester that did not win.
REQ-016 A requester SHALL deassert req at the edge ending its ack cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-017 At most one st bit SHALL be high in any cycle.
REQ-018 The ack and st pulses SHALL be coincident.

Reset
REQ-019 While rst is high, asynchronously and regardless of clk, the block SHALL force:
- state IDLE
- pointer 0
- st, ack, busy all 0
- d all 0
REQ-020 Reset asserted during WRITE SHALL abort the write: st and ack drop immediately, no ack is reissued, and the requester retries.
REQ-021 On the first edge after rst deasserts, the block SHALL perform normal IDLE sampling.

Configuration
REQ-022 With macro REG_WR_ARB_LOCK_EN defined, the block SHALL add input lock (2 bits). A winner whose lock bit is high when latched keeps the pointer on itself after WRITE, so it wins back-to-back contention.
REQ-023 Without REG_WR_ARB_LOCK_EN, the lock port SHALL not exist and pointer update SHALL follow REQ-015 only.

Verification
REQ-024 Single request: reset, then req=01, addr0=2, wdata0=16'hBEEF → next cycle st=4'b0100, d=16'hBEEF, ack=01, busy=1; following cycle st=0, ack=0.
REQ-025 Contention: req=11 held continuously with each side deasserting at its ack → acks alternate 01,10,01,10 with one idle cycle between writes.
REQ-026 Reset mid-WRITE: assert rst while st=0010 → st, ack, busy read 0 within the same cycle; after release, pointer=0, so req=11 grants requester 0 first.
REQ-027 Idle: req=00 for 10 cycles → st, ack and busy stay 0, and d keeps its last written value.
REQ-028 Lock (REG_WR_ARB_LOCK_EN defined): req=11, lock=01 → requester 0 acked twice in a row; drop lock[0] → the next grant goes to requester 1.
